// File: rtl/stopwatch_counter.sv
// stopwatch_counter: run/pause/clear stopwatch counting 1 Hz ticks into
// seconds and minutes. A full minutes:seconds wrap gives a one-cycle pulse.
// Optional lap capture is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
    parameter int MAX_SECONDS = 60,
    parameter int MAX_MINUTES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       second_tick,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic [5:0] lap_seconds,
    output logic [5:0] lap_minutes,
    output logic       lap_valid,
`endif
    output logic       enable,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       running,
    output logic       rollover
);

    // Terminal counts kept at counter width so the compares stay 6 bits.
    localparam logic [5:0] SEC_LAST = 6'(MAX_SECONDS - 1);
    localparam logic [5:0] MIN_LAST = 6'(MAX_MINUTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] seconds_q, seconds_d;
    logic [5:0] minutes_q, minutes_d;
    logic       rollover_q, rollover_d;

    logic       tick_counted;
    assign tick_counted = (state_q == RUNNING) && second_tick && !clear;

    // Next-state logic: clear beats start_stop; clear in IDLE changes nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_stop && !clear) state_d = RUNNING;
            end
            RUNNING: begin
                if (clear)           state_d = IDLE;
                else if (start_stop) state_d = PAUSED;
            end
            PAUSED: begin
                if (clear)           state_d = IDLE;
                else if (start_stop) state_d = RUNNING;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count update: zero in IDLE or on clear, advance only on ticks while running.
    always_comb begin
        seconds_d  = seconds_q;
        minutes_d  = minutes_q;
        rollover_d = 1'b0;
        if (clear || state_q == IDLE) begin
            seconds_d = 6'd0;
            minutes_d = 6'd0;
        end else if (tick_counted) begin
            if (seconds_q == SEC_LAST) begin
                seconds_d = 6'd0;
                if (minutes_q == MIN_LAST) begin
                    minutes_d  = 6'd0;
                    rollover_d = 1'b1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end
    end

    // State and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            seconds_q  <= 6'd0;
            minutes_q  <= 6'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seconds_q  <= seconds_d;
            minutes_q  <= minutes_d;
            rollover_q <= rollover_d;
        end
    end

    assign enable   = (state_q == RUNNING);
    assign running  = (state_q == RUNNING);
    assign seconds  = seconds_q;
    assign minutes  = minutes_q;
    assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic [5:0] lap_seconds_q, lap_seconds_d;
    logic [5:0] lap_minutes_q, lap_minutes_d;
    logic       lap_valid_q, lap_valid_d;

    // Lap capture takes the pre-increment count; clear wipes the lap.
    always_comb begin
        lap_seconds_d = lap_seconds_q;
        lap_minutes_d = lap_minutes_q;
        lap_valid_d   = lap_valid_q;
        if (clear) begin
            lap_seconds_d = 6'd0;
            lap_minutes_d = 6'd0;
            lap_valid_d   = 1'b0;
        end else if (lap && state_q == RUNNING) begin
            lap_seconds_d = seconds_q;
            lap_minutes_d = minutes_q;
            lap_valid_d   = 1'b1;
        end
    end

    // Lap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_seconds_q <= 6'd0;
            lap_minutes_q <= 6'd0;
            lap_valid_q   <= 1'b0;
        end else begin
            lap_seconds_q <= lap_seconds_d;
            lap_minutes_q <= lap_minutes_d;
            lap_valid_q   <= lap_valid_d;
        end
    end

    assign lap_seconds = lap_seconds_q;
    assign lap_minutes = lap_minutes_q;
    assign lap_valid   = lap_valid_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter (MAX_SECONDS=10, MAX_MINUTES=3). The reference
// model tracks elapsed time as one integer modulo the full period plus a mode.
module tb_stopwatch_counter;
    localparam int MS = 10;
    localparam int MM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       second_tick = 1'b0;
    logic       enable;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       running;
    logic       rollover;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
    logic [5:0] lap_seconds;
    logic [5:0] lap_minutes;
    logic       lap_valid;
`endif

    stopwatch_counter #(.MAX_SECONDS(MS), .MAX_MINUTES(MM)) dut (
        .clk(clk),
        .rst(rst),
        .start_stop(start_stop),
        .clear(clear),
        .second_tick(second_tick),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
        .lap_seconds(lap_seconds),
        .lap_minutes(lap_minutes),
        .lap_valid(lap_valid),
`endif
        .enable(enable),
        .seconds(seconds),
        .minutes(minutes),
        .running(running),
        .rollover(rollover)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0=idle 1=running 2=paused; total = elapsed seconds.
    int m_mode = 0;
    int m_total = 0;
    int m_roll = 0;
    int m_lap_s = 0;
    int m_lap_m = 0;
    int m_lap_v = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit ss, input bit clr, input bit tk, input bit lp);
        m_roll = 0;
        if (r) begin
            m_mode = 0; m_total = 0;
            m_lap_s = 0; m_lap_m = 0; m_lap_v = 0;
        end else if (clr) begin
            m_mode = 0; m_total = 0;
            m_lap_s = 0; m_lap_m = 0; m_lap_v = 0;
        end else begin
            if (m_mode == 1 && lp) begin
                m_lap_s = m_total % MS; m_lap_m = m_total / MS; m_lap_v = 1;
            end
            if (m_mode == 1 && tk) begin
                m_total = m_total + 1;
                if (m_total == MS * MM) begin
                    m_total = 0;
                    m_roll = 1;
                end
            end
            if (ss) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endtask

    // One clock cycle: drive, clock, update model, then compare everything.
    task automatic step(input bit r, input bit ss, input bit clr, input bit tk, input bit lp);
        rst = r; start_stop = ss; clear = clr; second_tick = tk;
`ifdef STOPWATCH_LAP_EN
        lap = lp;
`endif
        @(posedge clk);
        model_update(r, ss, clr, tk, lp);
        #1;
        check("seconds",  32'(seconds),  32'(m_total % MS));
        check("minutes",  32'(minutes),  32'(m_total / MS));
        check("enable",   32'(enable),   32'(m_mode == 1));
        check("running",  32'(running),  32'(m_mode == 1));
        check("rollover", 32'(rollover), 32'(m_roll));
`ifdef STOPWATCH_LAP_EN
        check("lap_seconds", 32'(lap_seconds), 32'(m_lap_s));
        check("lap_minutes", 32'(lap_minutes), 32'(m_lap_m));
        check("lap_valid",   32'(lap_valid),   32'(m_lap_v));
`endif
        $display("step rst=%0b ss=%0b clr=%0b tk=%0b lap=%0b -> sec=%0d min=%0d run=%0b roll=%0b",
                 r, ss, clr, tk, lp, seconds, minutes, running, rollover);
    endtask

    int roll_seen;

    initial begin
        #2;
        // Reset held two cycles while start_stop and tick are also high.
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check("reset_sec", 32'(seconds), 32'd0);
        check("reset_en",  32'(enable),  32'd0);

        // Start, then 12 ticks -> 1:02, never a rollover.
        step(0, 1, 0, 0, 0);
        roll_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 0);
            if (rollover) roll_seen++;
        end
        check("run12_sec", 32'(seconds), 32'd2);
        check("run12_min", 32'(minutes), 32'd1);
        check("run12_noroll", 32'(roll_seen), 32'd0);

        // Restart from zero: 29 ticks -> 2:09, one more wraps with rollover.
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 29; i++) step(0, 0, 0, 1, 0);
        check("pre_wrap_sec", 32'(seconds), 32'd9);
        check("pre_wrap_min", 32'(minutes), 32'd2);
        step(0, 0, 0, 1, 0);
        check("wrap_roll", 32'(rollover), 32'd1);
        check("wrap_run",  32'(running),  32'd1);
        step(0, 0, 0, 0, 0);
        check("wrap_roll_gone", 32'(rollover), 32'd0);

        // At 4 s, start_stop with tick: tick counts and we pause; later ticks ignored.
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        check("pause_sec", 32'(seconds), 32'd5);
        check("pause_en",  32'(enable),  32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("paused_hold", 32'(seconds), 32'd5);

        // Resume to 7 s, then clear+start_stop+tick together -> idle at zero.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1);   // lap while paused? no: clear cycle
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
        check("at7", 32'(seconds), 32'd7);
        step(0, 1, 1, 1, 0);
        check("clr_all_sec", 32'(seconds), 32'd0);
        check("clr_all_en",  32'(enable),  32'd0);

        // Clear in idle is a no-op; reset mid-count returns to idle.
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        check("mid_rst_sec", 32'(seconds), 32'd0);

        // Lap at 1:06, then lap while paused must not disturb it.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter MAX_SECONDS, default 60, seconds modulus (legal 2..64).
REQ-002 SHALL have parameter MAX_MINUTES, default 60, minutes modulus (legal 2..64).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-006 SHALL have port clear  input  1  single-cycle pulse; zeroes counts and returns to idle.
REQ-007 SHALL have port second_tick  input  1  one-cycle pulse from the upstream 1 Hz timer.
REQ-008 SHALL have port enable  output  1  drives the upstream timer's enable.
REQ-009 SHALL have port seconds  output  6  elapsed seconds, 0..MAX_SECONDS-1.
REQ-010 SHALL have port minutes  output  6  elapsed minutes, 0..MAX_MINUTES-1.
REQ-011 SHALL have port running  output  1  high when the state is RUNNING.
REQ-012 SHALL have port rollover  output  1  one-cycle pulse on full-count wrap.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, RUNNING and PAUSED.
REQ-014 IDLE: start_stop -> RUNNING; seconds and minutes SHALL be held at 0.
REQ-015 RUNNING: start_stop -> PAUSED; clear -> IDLE.
REQ-016 PAUSED: start_stop -> RUNNING; clear -> IDLE; counts SHALL be held.
REQ-017 clear in IDLE SHALL be a no-op; counts SHALL stay 0.
REQ-018 clear and start_stop asserted in the same cycle: clear SHALL win (next state IDLE, counts 0).
REQ-019 enable and running SHALL be decoded from the current state register only: 1 in RUNNING, 0 otherwise.
REQ-020 second_tick SHALL be counted only when the current state is RUNNING, and SHALL be ignored in IDLE and PAUSED.
REQ-021 A second_tick sampled in RUNNING in the same cycle as start_stop SHALL be counted, and the FSM SHALL still go to PAUSED.
REQ-022 A second_tick sampled in RUNNING in the same cycle as clear SHALL be discarded; counts SHALL become 0.
REQ-023 Latency: the count update SHALL be visible on the outputs in the cycle after the edge that sampled second_tick.
REQ-024 On a counted tick with seconds < MAX_SECONDS-1, seconds SHALL increment by 1.
REQ-025 On a counted tick with seconds == MAX_SECONDS-1, seconds SHALL become 0 and minutes SHALL increment by 1.
REQ-026 On a counted tick with seconds == MAX_SECONDS-1 and minutes == MAX_MINUTES-1, both SHALL become 0 and rollover SHALL pulse for exactly one cycle aligned with the wrapped value; the FSM SHALL stay RUNNING.
REQ-027 Counters SHALL be unsigned and 6 bits wide; the comparisons SHALL use the parameter value minus 1, with no wider intermediate.

Reset
REQ-028 When rst is high at a clock edge: state SHALL be IDLE, seconds = 0, minutes = 0, rollover = 0, enable = 0, running = 0.
REQ-029 rst SHALL override start_stop, clear and second_tick in the same cycle, including mid-count in RUNNING or PAUSED.
REQ-030 If STOPWATCH_LAP_EN is defined, reset SHALL also zero lap_seconds, lap_minutes and lap_valid.

Configuration
REQ-031 Macro STOPWATCH_LAP_EN, when defined, SHALL add these ports: lap (input, 1, pulse), lap_seconds (output, 6), lap_minutes (output, 6) and lap_valid (output, 1).
REQ-032 With STOPWATCH_LAP_EN defined, lap in RUNNING SHALL capture the pre-increment seconds/minutes into the lap registers and set lap_valid, with outputs visible next cycle.
REQ-033 With STOPWATCH_LAP_EN defined, lap in IDLE or PAUSED SHALL be ignored, and clear SHALL zero the lap registers and lap_valid.
REQ-034 Without STOPWATCH_LAP_EN, the lap ports and registers SHALL not exist, and the behaviour SHALL be identical to REQ-013..REQ-029.

Verification (MAX_SECONDS=10, MAX_MINUTES=3)
REQ-035 rst high for 2 cycles with start_stop and second_tick high -> state IDLE, seconds=0, minutes=0, enable=0.
REQ-036 start_stop, then 12 ticks -> enable=1, seconds=2, minutes=1; rollover never asserted.
REQ-037 From RUNNING, 29 ticks -> seconds=9, minutes=2; 1 more tick -> seconds=0, minutes=0, rollover high exactly one cycle.
REQ-038 At seconds=4, start_stop and second_tick in the same cycle -> seconds=5, state PAUSED, enable=0; 3 further ticks -> seconds stays 5.
REQ-039 At seconds=7, clear, start_stop and second_tick all in the same cycle -> IDLE, seconds=0, minutes=0, enable=0.
REQ-040 With STOPWATCH_LAP_EN defined: lap at seconds=6, minutes=1 -> lap_seconds=6, lap_minutes=1, lap_valid=1; a lap while PAUSED leaves these unchanged.
